// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scanner
package seg7_pkg;
  localparam int NUM_DIGITS = 8;
  // Segment patterns are active-high, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to active-high segment pattern; illegal codes show a dash
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 8-digit multiplexed seven-segment driver with per-frame input snapshot
// and an anti-ghosting blank at the start of every digit slot.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 100,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk_100kHz,
  input  logic       rst,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd4,
  input  logic [3:0] bcd5,
  input  logic [3:0] bcd6,
  input  logic [3:0] bcd7,
  input  logic [7:0] en,
  input  logic [7:0] dp,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       seg_dp,
  output logic       frame_tick
);
  localparam logic [15:0] SLOT_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [1:0]  ST_FIRST   = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
  localparam logic        SEG_INV    = SEG_ACTIVE_LOW != 0;
  localparam logic        AN_INV     = AN_ACTIVE_LOW != 0;

  logic [1:0]  r_state;
  logic [2:0]  r_idx;
  logic [15:0] r_cnt;
  logic [3:0]  r_bcd [NUM_DIGITS];
  logic [7:0]  r_en;
  logic [7:0]  r_dp;
  logic        w_slot_end;
  logic [6:0]  w_pat;
  logic [7:0]  w_an;
  logic [6:0]  w_seg;
  logic        w_dp;

  bcd_to_seg7 u_dec (.i_bcd(r_bcd[r_idx]), .o_seg(w_pat));

  assign w_slot_end = (r_state == ST_SHOW) && (r_cnt == SLOT_LAST);
  assign w_an       = (r_state == ST_SHOW && r_en[r_idx]) ? 8'd1 << r_idx : 8'd0;
  assign w_seg      = (r_state == ST_LOAD) ? 7'd0 : w_pat;
  assign w_dp       = (r_state == ST_SHOW) && r_dp[r_idx];

  always_ff @(posedge clk_100kHz or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '{default: '0};
      r_en    <= '0;
      r_dp    <= '0;
    end else if (r_state == ST_LOAD) begin
      r_bcd   <= '{bcd0, bcd1, bcd2, bcd3, bcd4, bcd5, bcd6, bcd7};
      r_en    <= en;
      r_dp    <= dp;
      r_cnt   <= '0;
      r_state <= ST_FIRST;
    end else if (w_slot_end) begin
      r_cnt   <= '0;
      r_idx   <= r_idx + 3'd1;
      r_state <= (r_idx == 3'(NUM_DIGITS - 1)) ? ST_LOAD : ST_FIRST;
    end else begin
      r_cnt   <= r_cnt + 16'd1;
      if (r_state == ST_BLANK && r_cnt == BLANK_LAST) r_state <= ST_SHOW;
    end
  end

  // Outputs lag the FSM by one cycle so every pin comes straight from a flop
  always_ff @(posedge clk_100kHz or posedge rst) begin
    if (rst) begin
      an         <= {8{AN_INV}};
      seg        <= {7{SEG_INV}};
      seg_dp     <= SEG_INV;
      frame_tick <= 1'b0;
    end else begin
      an         <= w_an ^ {8{AN_INV}};
      seg        <= w_seg ^ {7{SEG_INV}};
      seg_dp     <= w_dp ^ SEG_INV;
      frame_tick <= r_state == ST_LOAD;
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized bench checking seg7_scan against a frame-arithmetic model
module tb_seg7_scan;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FL = 8 * SD + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bcd [8];
  logic [7:0] en;
  logic [7:0] dp;
  logic [7:0] an;
  logic [6:0] seg;
  logic       seg_dp;
  logic       frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int j = 0;
  int last_tick = -1;
  logic [3:0] m_bcd [8];
  logic [7:0] m_en;
  logic [7:0] m_dp;

  always #5 clk = ~clk;

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clk_100kHz(clk), .rst(rst),
    .bcd0(bcd[0]), .bcd1(bcd[1]), .bcd2(bcd[2]), .bcd3(bcd[3]),
    .bcd4(bcd[4]), .bcd5(bcd[5]), .bcd6(bcd[6]), .bcd7(bcd[7]),
    .en(en), .dp(dp), .an(an), .seg(seg), .seg_dp(seg_dp), .frame_tick(frame_tick)
  );

  always @(negedge clk) assert ($onehot0(~an)) else $error("FAIL onehot an=%h", an);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, j);
    end
  endtask

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B; 4'd3: return 7'h4F;
      4'd4: return 7'h66; 4'd5: return 7'h6D; 4'd6: return 7'h7D; 4'd7: return 7'h07;
      4'd8: return 7'h7F; 4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic check_reset_vals();
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", seg_dp, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
  endtask

  // Cycle j after release shows what the FSM did in frame position (j-1) mod FL
  task automatic step();
    int p, s, c;
    logic [7:0] ea;
    logic [6:0] es;
    logic ed, et;
    @(posedge clk);
    #1;
    j++;
    p = (j - 1) % FL;
    if (p == 0) begin
      m_bcd = bcd;
      m_en  = en;
      m_dp  = dp;
      ea = 8'hFF; es = 7'h7F; ed = 1'b1; et = 1'b1;
    end else begin
      s  = (p - 1) / SD;
      c  = (p - 1) % SD;
      es = ~pat(m_bcd[s]);
      et = 1'b0;
      if (c < BC) begin
        ea = 8'hFF; ed = 1'b1;
      end else begin
        ea = m_en[s] ? ~(8'd1 << s) : 8'hFF;
        ed = ~m_dp[s];
      end
    end
    check("an", an, ea);
    check("seg", seg, es);
    check("seg_dp", seg_dp, ed);
    check("tick", frame_tick, et);
    if (frame_tick) begin
      if (last_tick >= 0) check("frame_len", j - last_tick, FL);
      last_tick = j;
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    j = 0;
    last_tick = -1;
  endtask

  initial begin
    int p;
    bit found;
    for (int i = 0; i < 8; i++) bcd[i] = 4'(8 - i);
    en = 8'hFF;
    dp = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    release_rst();
    repeat (2 * FL) step();
    en = 8'h0F;
    dp = 8'h02;
    bcd[2] = 4'hC;
    bcd[0] = 4'd3;
    repeat (FL + FL / 2) step();
    bcd[0] = 4'd9;
    repeat (2 * FL) step();
    en = 8'hFF;
    repeat (8 * FL) begin
      step();
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, 9);
        if (p < 8) bcd[p] = 4'($urandom);
        else if (p == 8) en = 8'($urandom);
        else dp = 8'($urandom);
      end
    end
    en = 8'hFF;
    found = 1'b0;
    for (int n = 0; n < 3 * FL && !found; n++) begin
      step();
      p = j % FL;
      found = p != 0 && (p - 1) / SD == 5 && (p - 1) % SD >= BC;
    end
    check("find_slot5", found, 1'b1);
    #3 rst = 1'b1;
    #2;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    release_rst();
    repeat (2 * FL) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
